// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand select, load-use hazard detection and
// EX/MEM, MEM/WB operand forwarding (enabled by the ID_EX_FORWARDING_EN macro).
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_alu_ctrl,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic        id_alu_src,
  input  logic [4:0]  id_sa,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        mwb_reg_write,
  input  logic [4:0]  mwb_rd,
  input  logic [31:0] mwb_data,
  output logic [3:0]  ALUControl,
  output logic [31:0] reg_A,
  output logic [31:0] reg_B,
  output logic [4:0]  sa,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_dst,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_valid,
  output logic        load_use_stall
);

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic        alu_src;
    logic [4:0]  sa;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        valid;
  } id_ex_t;

  id_ex_t stage_reg;
  id_ex_t stage_next;
  id_ex_t id_fields;

  assign id_fields = '{
    alu_ctrl:   id_alu_ctrl,
    rs_data:    id_rs_data,
    rt_data:    id_rt_data,
    imm:        id_imm,
    alu_src:    id_alu_src,
    sa:         id_sa,
    rs:         id_rs,
    rt:         id_rt,
    dst:        id_dst,
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    valid:      id_valid
  };

`ifdef ID_EX_FORWARDING_EN
  // A load in EX whose result a decoding instruction needs cannot be forwarded
  // in time; a taken branch kills the decode slot, so no hazard then.
  assign load_use_stall = ~flush & id_valid & stage_reg.valid & stage_reg.mem_read &
                          (stage_reg.dst != 5'd0) &
                          ((stage_reg.dst == id_rs) | (stage_reg.dst == id_rt));
`else
  assign load_use_stall = 1'b0;
`endif

  // Bubble = all-zero record, so every control bit and valid drop together.
  always_comb begin
    stage_next = stage_reg;
    if (flush) begin
      stage_next = '0;
    end else if (stall) begin
      stage_next = stage_reg;
    end else if (load_use_stall) begin
      stage_next = '0;
    end else begin
      stage_next = id_fields;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Operand 0 is rs, operand 1 is rt; both share the same forwarding network.
  logic [1:0][4:0]  src_idx;
  logic [1:0][31:0] src_data;
  logic [1:0][31:0] fwd_data;

  assign src_idx[0]  = stage_reg.rs;
  assign src_idx[1]  = stage_reg.rt;
  assign src_data[0] = stage_reg.rs_data;
  assign src_data[1] = stage_reg.rt_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
`ifdef ID_EX_FORWARDING_EN
      logic exm_hit;
      logic mwb_hit;
      assign exm_hit = exm_reg_write & (exm_rd != 5'd0) & (exm_rd == src_idx[gi]);
      assign mwb_hit = mwb_reg_write & (mwb_rd != 5'd0) & (mwb_rd == src_idx[gi]);
      // EX/MEM is the younger producer, so it wins over MEM/WB.
      assign fwd_data[gi] = exm_hit ? exm_result :
                            mwb_hit ? mwb_data   : src_data[gi];
`else
      assign fwd_data[gi] = src_data[gi];
`endif
    end
  endgenerate

`ifndef ID_EX_FORWARDING_EN
  // Without forwarding the bypass inputs and source indices have no consumer.
  logic unused_fwd;
  assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result,
                        mwb_reg_write, mwb_rd, mwb_data, src_idx};
`endif

  assign ALUControl    = stage_reg.alu_ctrl;
  assign sa            = stage_reg.sa;
  assign reg_A         = fwd_data[0];
  assign ex_store_data = fwd_data[1];
  assign reg_B         = stage_reg.alu_src ? stage_reg.imm : fwd_data[1];
  assign ex_dst        = stage_reg.dst;
  assign ex_reg_write  = stage_reg.reg_write;
  assign ex_mem_read   = stage_reg.mem_read;
  assign ex_mem_write  = stage_reg.mem_write;
  assign ex_mem_to_reg = stage_reg.mem_to_reg;
  assign ex_valid      = stage_reg.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, zero register,
// load-use bubble, stall/flush and asynchronous mid-run reset.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [3:0]  id_alu_ctrl;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alu_src;
  logic [4:0]  id_sa, id_rs, id_rt, id_dst;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_result, mwb_data;
  logic [3:0]  ALUControl;
  logic [31:0] reg_A, reg_B, ex_store_data;
  logic [4:0]  sa, ex_dst;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_valid;
  logic        load_use_stall;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_ctrl(id_alu_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_src(id_alu_src), .id_sa(id_sa), .id_rs(id_rs),
    .id_rt(id_rt), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_data(mwb_data), .ALUControl(ALUControl), .reg_A(reg_A), .reg_B(reg_B),
    .sa(sa), .ex_store_data(ex_store_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_valid(ex_valid), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("t=%0t %s observed=%h", $time, tag, obs);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] ctrl, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm,
                           input logic asrc, input logic [4:0] s, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] dst,
                           input logic rw, input logic mr, input logic mw, input logic m2r);
    id_valid = 1'b1; id_alu_ctrl = ctrl; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_alu_src = asrc; id_sa = s; id_rs = rs; id_rt = rt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_mem_to_reg = m2r;
  endtask

  task automatic clear_bypass();
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_data = '0;
  endtask

  initial begin
    // Reset with busy inputs: outputs must be zero without any clock edge.
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    clear_bypass();
    set_instr(4'hF, 32'hAAAA_5555, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 5'd31,
              5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    chk("rst_reg_A", reg_A, 32'h0);
    chk("rst_reg_B", reg_B, 32'h0);
    chk("rst_ctrl", {28'h0, ALUControl}, 32'h0);
    step();
    id_rs_data = 32'h0BAD_F00D;
    step();
    chk("rst_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_store", ex_store_data, 32'h0);
    chk("rst_lus", {31'h0, load_use_stall}, 32'h0);
    reset = 1'b0;

    // addi $2, $1, 5 with $1 = 7
    set_instr(4'b0010, 32'd7, 32'd0, 32'd5, 1'b1, 5'd0, 5'd1, 5'd2, 5'd2,
              1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("addi_reg_A", reg_A, 32'd7);
    chk("addi_reg_B", reg_B, 32'd5);
    chk("addi_ctrl", {28'h0, ALUControl}, 32'h2);
    chk("addi_dst", {27'h0, ex_dst}, 32'd2);
    chk("addi_valid", {31'h0, ex_valid}, 32'h1);

    // Forwarding onto rs=8, rt=3
    set_instr(4'b0010, 32'h111, 32'h33, 32'h0, 1'b0, 5'd0, 5'd8, 5'd3, 5'd4,
              1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exm_reg_write = 1'b1; exm_rd = 5'd8; exm_result = 32'h10;
    #1;
    chk("fwd_exm_A", reg_A, FWD ? 32'h10 : 32'h111);
    chk("fwd_exm_B", reg_B, 32'h33);
    mwb_reg_write = 1'b1; mwb_rd = 5'd8; mwb_data = 32'h20;
    #1;
    chk("fwd_both_A", reg_A, FWD ? 32'h10 : 32'h111);
    exm_reg_write = 1'b0;
    #1;
    chk("fwd_mwb_A", reg_A, FWD ? 32'h20 : 32'h111);
    mwb_rd = 5'd3;
    #1;
    chk("fwd_mwb_B", reg_B, FWD ? 32'h20 : 32'h33);
    chk("fwd_mwb_st", ex_store_data, FWD ? 32'h20 : 32'h33);
    chk("fwd_none_A", reg_A, 32'h111);
    clear_bypass();

    // Zero register is never forwarded
    set_instr(4'b0010, 32'h55, 32'h66, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd6,
              1'b1, 1'b0, 1'b0, 1'b0);
    step();
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hDEAD;
    mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_data = 32'hBEEF;
    #1;
    chk("zero_A", reg_A, 32'h55);
    chk("zero_B", reg_B, 32'h66);
    clear_bypass();

    // lw $9, 4($1) followed by dependent add $10, $9, $5
    set_instr(4'b0010, 32'h100, 32'h0, 32'd4, 1'b1, 5'd0, 5'd1, 5'd9, 5'd9,
              1'b1, 1'b1, 1'b0, 1'b1);
    step();
    chk("lw_memread", {31'h0, ex_mem_read}, 32'h1);
    set_instr(4'b0010, 32'hAA, 32'hBB, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5, 5'd10,
              1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lu_stall", {31'h0, load_use_stall}, FWD ? 32'h1 : 32'h0);
    flush = 1'b1;
    #1;
    chk("lu_flush_gate", {31'h0, load_use_stall}, 32'h0);
    flush = 1'b0;
    step();
    chk("lu_bubble_valid", {31'h0, ex_valid}, FWD ? 32'h0 : 32'h1);
    chk("lu_bubble_dst", {27'h0, ex_dst}, FWD ? 32'd0 : 32'd10);
    chk("lu_after_stall", {31'h0, load_use_stall}, 32'h0);
    step();
    chk("lu_add_valid", {31'h0, ex_valid}, 32'h1);
    chk("lu_add_dst", {27'h0, ex_dst}, 32'd10);
    chk("lu_add_A", reg_A, 32'hAA);

    // Stall for three cycles, then flush together with stall
    set_instr(4'b0110, 32'h1234, 32'h5678, 32'h0, 1'b0, 5'd7, 5'd12, 5'd13, 5'd11,
              1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("pre_stall_A", reg_A, 32'h1234);
    stall = 1'b1;
    set_instr(4'b0001, 32'hFFFF, 32'hEEEE, 32'h0, 1'b0, 5'd2, 5'd14, 5'd15, 5'd12,
              1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_A", reg_A, 32'h1234);
      chk("stall_ctrl", {28'h0, ALUControl}, 32'h6);
      chk("stall_dst", {27'h0, ex_dst}, 32'd11);
      chk("stall_sa", {27'h0, sa}, 32'd7);
    end
    flush = 1'b1;
    step();
    chk("flush_valid", {31'h0, ex_valid}, 32'h0);
    chk("flush_rw", {31'h0, ex_reg_write}, 32'h0);
    chk("flush_mw", {31'h0, ex_mem_write}, 32'h0);
    chk("flush_A", reg_A, 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset between clock edges
    step();
    chk("pre_areset_valid", {31'h0, ex_valid}, 32'h1);
    chk("pre_areset_B", reg_B, 32'hEEEE);
    reset = 1'b1;
    #1;
    chk("areset_valid", {31'h0, ex_valid}, 32'h0);
    chk("areset_B", reg_B, 32'h0);
    chk("areset_mw", {31'h0, ex_mem_write}, 32'h0);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
